muldiv_unit: RTL
================

# muldiv_unit

Multi-cycle 16-bit multiply/divide unit for the MIPS datapath. Consumes the two operands read from the 8×16 register file and produces a 16-bit result for writeback into the register file's write port. Also keeps an internal HI register: the upper product half or the remainder. Runs as an iterative shift-add / restoring-divide engine with a start/busy handshake and a valid/ready writeback handshake.

## Interface
Parameters:
- WIDTH, 16, operand/result width (must match register file data width)
- REG_AW, 3, destination register address width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  2  00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed)
- src_a  in  WIDTH  multiplicand / dividend (register file read_data1)
- src_b  in  WIDTH  multiplier / divisor (register file read_data2)
- dest_reg  in  REG_AW  destination register number
- busy  out  1  high in every state except IDLE
- wb_valid  out  1  result ready for register file write
- wb_ready  in  1  register file write port granted this cycle
- wb_reg  out  REG_AW  destination register for writeback
- wb_data  out  WIDTH  product low half or quotient
- hi_out  out  WIDTH  HI register (product high half or remainder)

## Operation
- States: IDLE, RUN, FIX, WB.
- IDLE: start=1 latches op, src_a, src_b, dest_reg, clears count, goes to RUN. start=0 stays in IDLE.
- Signed ops convert operands to magnitudes at latch time and record the result signs.
- RUN: one iteration per cycle, 5-bit count 0..15. At count=15 it goes to FIX.
  - Multiply: 32-bit shift-add, LSB-first.
  - Divide: restoring, MSB-first, 17-bit partial remainder.
- FIX: applies signs to the results.
  - Product: negated when the operand signs differ.
  - Quotient: negated when the operand signs differ. Truncates toward zero.
  - Remainder: takes the dividend's sign.
  - Loads wb_data and hi_out, then goes to WB.
- WB: holds wb_valid=1. On wb_valid&&wb_ready it goes to IDLE. hi_out keeps its value until the next FIX or rst.
- Divide by zero: quotient 0xFFFF, remainder = src_a. Same latency as a normal op, no early exit.
- Signed overflow 0x8000 / 0xFFFF: quotient 0x8000, remainder 0x0000.
- start while busy is ignored. It is not queued.
- Any op/src/dest_reg change after the latch has no effect on the result.

## Timing
- Reset values (rst=1 at an edge): state IDLE, busy 0, wb_valid 0, wb_reg 0, wb_data 0x0000, hi_out 0x0000, count 0.
- rst wins over every other event, including mid-RUN and during WB. The in-flight op is discarded with no writeback.
- Latency: start sampled at edge E0 → busy=1 after E0 → wb_valid=1 after E17. That is 16 RUN edges plus 1 FIX edge, 18 cycles from start to wb_valid.
- While wb_valid=1 and wb_ready=0: wb_reg, wb_data and hi_out are stable.
- Handshake at edge En → wb_valid=0 and busy=0 after En. The next start can be sampled at En+1.
- Minimum issue interval: 19 cycles.
- wb_ready while not in WB is ignored.

## Configuration
- MULDIV_DIV_EN defined: full divider datapath and ops 10/11 behave as above.
- MULDIV_DIV_EN undefined: divider logic is compiled out.
  - Ops 10/11 are still accepted. They go straight IDLE→WB after one edge.
  - Result: wb_data=0x0000, hi_out=0x0000.
  - Multiply behaviour and latency are unchanged.

## Structure
- Package muldiv_pkg holds:
  - op encoding enum (OP_MULU, OP_MUL, OP_DIVU, OP_DIV)
  - state enum
  - WIDTH=16 and ITER=16 constants
  - DIV0_QUOT=16'hFFFF constant
- One sub-module, muldiv_step: a combinational single-iteration datapath.
  - Multiply: conditional add and shift.
  - Divide: trial subtract, restore, quotient bit.
  - The FSM, counter, sign fix-up and handshake stay in muldiv_unit.

## Test plan
- MULU 0x00FF×0x0101, dest 3, wb_ready=1 → wb_valid exactly 18 cycles after start. Expect wb_reg=3, wb_data=0xFFFF, hi_out=0x0000.
- MUL 0xFFFE×0x0003 → wb_data=0xFFFA, hi_out=0xFFFF.
- DIV 0xFFF9/0x0002 (−7/2) → wb_data=0xFFFD, hi_out=0xFFFF.
- DIVU 100/7 → wb_data=0x000E, hi_out=0x0002.
- Division corner cases:
  - DIVU 0x1234/0 → wb_data=0xFFFF, hi_out=0x1234.
  - DIV 0x8000/0xFFFF → wb_data=0x8000, hi_out=0x0000.
- Handshake back-pressure: hold wb_ready=0 for 5 cycles in WB and pulse start during RUN and WB.
  - Outputs stay stable and the extra starts are ignored.
  - After wb_ready=1, busy=0 next cycle.
- Reset mid-operation: rst at RUN count 8 → next cycle busy=0, wb_valid=0, hi_out=0. A fresh MULU 2×3 then yields wb_data=0x0006.
- Config check: with MULDIV_DIV_EN undefined, DIVU 100/7 → wb_valid after 1 cycle, wb_data=0x0000, hi_out=0x0000.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int WIDTH = 16;
    localparam int ITER  = 16;
    localparam logic [WIDTH-1:0] DIV0_QUOT = 16'hFFFF;

    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_MUL  = 2'b01,
        OP_DIVU = 2'b10,
        OP_DIV  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_WB   = 2'b11
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply (LSB-first) or restoring divide (MSB-first).
// Build option MULDIV_DIV_EN: include the trial-subtract divider path.
module muldiv_step #(
    parameter int W = 16
) (
    input  logic         is_div,
    input  logic [W-1:0] operand,
    input  logic [W-1:0] hi_in,
    input  logic [W-1:0] lo_in,
    output logic [W-1:0] hi_out,
    output logic [W-1:0] lo_out
);

    logic [W:0] mul_sum;

    always_comb begin
        mul_sum = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : {(W+1){1'b0}});
    end

`ifdef MULDIV_DIV_EN
    logic [W:0]   shifted;
    logic [W+1:0] trial;
    logic         unused_trial_msb;

    // The partial remainder stays below the divisor, so a non-negative trial fits in W bits.
    assign unused_trial_msb = trial[W];

    always_comb begin
        shifted = {hi_in, lo_in[W-1]};
        trial   = {1'b0, shifted} - {2'b00, operand};
        hi_out  = mul_sum[W:1];
        lo_out  = {mul_sum[0], lo_in[W-1:1]};
        if (is_div) begin
            if (trial[W+1]) begin
                hi_out = shifted[W-1:0];
                lo_out = {lo_in[W-2:0], 1'b0};
            end else begin
                hi_out = trial[W-1:0];
                lo_out = {lo_in[W-2:0], 1'b1};
            end
        end
    end
`else
    always_comb begin
        hi_out = is_div ? {W{1'b0}} : mul_sum[W:1];
        lo_out = is_div ? {W{1'b0}} : {mul_sum[0], lo_in[W-1:1]};
    end
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 16-bit multiply/divide unit with start/busy request and valid/ready writeback.
// Build option MULDIV_DIV_EN: enables divide; otherwise divide ops return zero after one cycle.
module muldiv_unit #(
    parameter int WIDTH  = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  src_a,
    input  logic [WIDTH-1:0]  src_b,
    input  logic [REG_AW-1:0] dest_reg,
    output logic              busy,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [REG_AW-1:0] wb_reg,
    output logic [WIDTH-1:0]  wb_data,
    output logic [WIDTH-1:0]  hi_out
);
    import muldiv_pkg::*;

    state_e              state_q, state_d;
    op_e                 op_q, op_d, in_op;
    logic [4:0]          count_q, count_d;
    logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]    acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]    wb_data_q, wb_data_d, hi_q, hi_d;
    logic [REG_AW-1:0]   dest_q, dest_d, wb_reg_q, wb_reg_d;
    logic                neg_q, neg_d;
    logic                in_signed, in_div, is_div;
    logic [WIDTH-1:0]    a_abs, b_abs, step_hi, step_lo;
    logic [2*WIDTH-1:0]  prod_fix;
`ifdef MULDIV_DIV_EN
    logic                rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]    quot_fix, rem_fix;
`endif

    // Operand conditioning at latch time: signed ops work on magnitudes.
    always_comb begin
        in_op     = op_e'(op);
        in_signed = (in_op == OP_MUL) || (in_op == OP_DIV);
        in_div    = (in_op == OP_DIVU) || (in_op == OP_DIV);
        a_abs     = (in_signed && src_a[WIDTH-1]) ? (~src_a + 1'b1) : src_a;
        b_abs     = (in_signed && src_b[WIDTH-1]) ? (~src_b + 1'b1) : src_b;
        is_div    = (op_q == OP_DIVU) || (op_q == OP_DIV);
        prod_fix  = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    end

`ifdef MULDIV_DIV_EN
    always_comb begin
        quot_fix = neg_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
        if (b_q == '0) begin
            quot_fix = DIV0_QUOT;
        end
        rem_fix = rem_neg_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
    end
`endif

    muldiv_step #(.W(WIDTH)) u_step (
        .is_div  (is_div),
        .operand (is_div ? b_q : a_q),
        .hi_in   (acc_hi_q),
        .lo_in   (acc_lo_q),
        .hi_out  (step_hi),
        .lo_out  (step_lo)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        count_d   = count_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        dest_d    = dest_q;
        neg_d     = neg_q;
        wb_reg_d  = wb_reg_q;
        wb_data_d = wb_data_q;
        hi_d      = hi_q;
`ifdef MULDIV_DIV_EN
        rem_neg_d = rem_neg_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d     = in_op;
                    a_d      = a_abs;
                    b_d      = b_abs;
                    dest_d   = dest_reg;
                    count_d  = '0;
                    neg_d    = in_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                    acc_hi_d = '0;
                    acc_lo_d = in_div ? a_abs : b_abs;
                    state_d  = ST_RUN;
`ifdef MULDIV_DIV_EN
                    rem_neg_d = in_signed && src_a[WIDTH-1];
`else
                    if (in_div) begin
                        wb_reg_d  = dest_reg;
                        wb_data_d = '0;
                        hi_d      = '0;
                        state_d   = ST_WB;
                    end
`endif
                end
            end
            ST_RUN: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                count_d  = count_q + 5'd1;
                if (count_q == 5'(ITER - 1)) begin
                    count_d = '0;
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                wb_reg_d  = dest_q;
                wb_data_d = prod_fix[WIDTH-1:0];
                hi_d      = prod_fix[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
                if (is_div) begin
                    wb_data_d = quot_fix;
                    hi_d      = rem_fix;
                end
`endif
                state_d = ST_WB;
            end
            ST_WB: begin
                if (wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            wb_reg_q  <= '0;
            wb_data_q <= '0;
            hi_q      <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wb_reg_q  <= wb_reg_d;
            wb_data_q <= wb_data_d;
            hi_q      <= hi_d;
        end
    end

    // Working datapath registers are only meaningful after a latch, so they carry no reset.
    always_ff @(posedge clk) begin
        op_q     <= op_d;
        a_q      <= a_d;
        b_q      <= b_d;
        acc_hi_q <= acc_hi_d;
        acc_lo_q <= acc_lo_d;
        dest_q   <= dest_d;
        neg_q    <= neg_d;
`ifdef MULDIV_DIV_EN
        rem_neg_q <= rem_neg_d;
`endif
    end

    assign busy     = (state_q != ST_IDLE);
    assign wb_valid = (state_q == ST_WB);
    assign wb_reg   = wb_reg_q;
    assign wb_data  = wb_data_q;
    assign hi_out   = hi_q;

endmodule
